restoring_divider_four_bit: RTL and testbench



---
 rtl/restoring_divider_four_bit.sv | 132 +++++++++++++
 tb/tb_restoring_divider_four_bit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_four_bit.sv
// +--------------------------------------------------------------------------+
// | restoring_divider_four_bit : unsigned restoring divider, 1 quotient bit   |
// | per clock. Optional macro DIV_BY_ZERO_DETECT_EN adds a 1-cycle x/0 exit.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module restoring_divider_four_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q,   rem_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] dvsr_q,  dvsr_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             accept;

`ifdef DIV_BY_ZERO_DETECT_EN
  logic             dbz_q, dbz_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
`ifdef DIV_BY_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
`ifdef DIV_BY_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif

    // The borrow out of the (WIDTH+1)-bit trial subtraction decides the bit.
    rem_shift = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    accept    = start && (state_q != S_RUN);

    case (state_q)
      S_RUN: begin
        if (!trial[WIDTH]) begin
          rem_d  = trial;
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift;
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      quot_d  = dividend;
      dvsr_d  = divisor;
      rem_d   = '0;
      count_d = CW'(WIDTH);
      state_d = S_RUN;
`ifdef DIV_BY_ZERO_DETECT_EN
      dbz_d   = 1'b0;
      if (divisor == '0) begin
        quot_d  = '1;
        rem_d   = {1'b0, dividend};
        count_d = '0;
        dbz_d   = 1'b1;
        state_d = S_DONE;
      end
`endif
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q[WIDTH-1:0];

`ifdef DIV_BY_ZERO_DETECT_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider_four_bit.sv
// +--------------------------------------------------------------------------+
// | tb_restoring_divider_four_bit : directed and sweep bench for the divider  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_restoring_divider_four_bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks;
  int errors;

`ifdef DIV_BY_ZERO_DETECT_EN
  localparam int ZLAT = 1;
  localparam int ZDBZ = 1;
`else
  localparam int ZLAT = 5;
  localparam int ZDBZ = 0;
`endif

  restoring_divider_four_bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division, track busy each cycle, then check latency and results.
  task automatic run_div(input logic [3:0] dd, input logic [3:0] ds,
                         input int exp_q, input int exp_r, input int exp_dbz,
                         input int exp_lat, input bit chk_busy);
    int n;
    start    = 1'b1;
    dividend = dd;
    divisor  = ds;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n <= 20) begin
      if (chk_busy) check("busy_in_run", busy, 1);
      tick();
      n++;
    end
    check("latency", n, exp_lat);
    check("busy_at_done", busy, 0);
    check("quotient", quotient, exp_q);
    check("remainder", remainder, exp_r);
    check("div_by_zero", div_by_zero, exp_dbz);
  endtask

  task automatic idle_check_hold(input int exp_q, input int exp_r);
    tick();
    check("done_pulse_one_cycle", done, 0);
    check("hold_quotient", quotient, exp_q);
    check("hold_remainder", remainder, exp_r);
    tick();
  endtask

  initial begin
    bit saw_done;
    int q_m, r_m, l_m, z_m;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    rst = 1'b0;
    tick();

    run_div(4'd13, 4'd3, 4, 1, 0, 5, 1'b1);
    idle_check_hold(4, 1);
    run_div(4'd15, 4'd1, 15, 0, 0, 5, 1'b1);
    idle_check_hold(15, 0);
    run_div(4'd7, 4'd9, 0, 7, 0, 5, 1'b1);
    idle_check_hold(0, 7);
    run_div(4'd15, 4'd15, 1, 0, 0, 5, 1'b1);
    idle_check_hold(1, 0);
    run_div(4'd0, 4'd5, 0, 0, 0, 5, 1'b1);
    idle_check_hold(0, 0);
    run_div(4'd9, 4'd0, 15, 9, ZDBZ, ZLAT, 1'b1);
    idle_check_hold(15, 9);

    // 12/5 with an ignored 3/2 request mid-run, then 14/4 presented with done.
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    start = 1'b1; dividend = 4'd3; divisor = 4'd2;
    tick();                                   // cycle 3
    tick();                                   // cycle 4
    start = 1'b0;
    check("ignore_busy_c4", busy, 1);
    tick();                                   // cycle 5
    check("ignore_done_c5", done, 1);
    check("ignore_q", quotient, 2);
    check("ignore_r", remainder, 2);
    run_div(4'd14, 4'd4, 3, 2, 0, 5, 1'b1);
    idle_check_hold(3, 2);

    // Reset in the middle of a run discards it.
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("midrst_no_done", saw_done, 0);
    run_div(4'd6, 4'd4, 1, 2, 0, 5, 1'b1);
    idle_check_hold(1, 2);

    // Exhaustive back-to-back sweep against the arithmetic definition.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          q_m = 15; r_m = a; l_m = ZLAT; z_m = ZDBZ;
        end else begin
          q_m = a / b; r_m = a % b; l_m = 5; z_m = 0;
        end
        run_div(4'(a), 4'(b), q_m, r_m, z_m, l_m, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
